// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - data memory controller: local RAM plus timed peripheral port (optional DMEM_ALIGN_CHECK_EN)
module data_mem_ctrl #(
    parameter int RAM_WORDS    = 256,
    parameter int PERI_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        p_rd,
    output logic        p_wr,
    output logic [31:0] p_addr,
    output logic [31:0] p_wdata,
    output logic [3:0]  p_be,
    input  logic [31:0] p_rdata,
    input  logic        p_ack
);
    localparam int AW = $clog2(RAM_WORDS);

    typedef enum logic [1:0] {IDLE, RAM_DONE, PERI_WAIT, DONE} state_t;

    state_t      state_q;
    logic [31:0] rdata_q;
    logic        ready_q;
    logic        err_q;
    logic        p_rd_q;
    logic        p_wr_q;
    logic [31:0] p_addr_q;
    logic [31:0] p_wdata_q;
    logic [3:0]  p_be_q;
    logic [7:0]  cnt_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [1:0]  lo_q;
    logic        wr_op_q;

    logic [31:0] mem [RAM_WORDS];

    logic        req_d;
    logic        is_ram_d;
    logic        misalign_d;
    logic [3:0]  be_d;
    logic [31:0] lane_wdata_d;
    logic [31:0] ram_word_d;

    // Pick the addressed byte/half lane out of a word and extend it to 32 bits.
    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] sz,
                                            input logic sgn, input logic [1:0] lo);
        logic [31:0] sh;
        logic [15:0] h;
        sh = word >> {lo, 3'b000};
        h  = lo[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   extract = {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   extract = {{16{sgn & h[15]}}, h};
            default: extract = word;
        endcase
    endfunction

    assign req_d      = rd | wr;
    assign is_ram_d   = addr < 32'(RAM_WORDS * 4);
    assign ram_word_d = mem[addr[AW+1:2]];

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign_d = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
    assign misalign_d = 1'b0;
`endif

    // Byte enables and lane-aligned store data for the requested size.
    always_comb begin
        be_d         = 4'b1111;
        lane_wdata_d = wdata;
        case (size)
            2'b00: begin
                be_d         = 4'b0001 << addr[1:0];
                lane_wdata_d = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_d         = addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata_d = {2{wdata[15:0]}};
            end
            default: begin
                be_d         = 4'b1111;
                lane_wdata_d = wdata;
            end
        endcase
        lane_wdata_d = lane_wdata_d & {{8{be_d[3]}}, {8{be_d[2]}}, {8{be_d[1]}}, {8{be_d[0]}}};
    end

    // RAM store: only enabled lanes change, only at the accepting edge.
    always_ff @(posedge clk) begin
        if (!reset && state_q == IDLE && wr && is_ram_d && !misalign_d) begin
            for (int i = 0; i < 4; i++) begin
                if (be_d[i]) mem[addr[AW+1:2]][i*8 +: 8] <= lane_wdata_d[i*8 +: 8];
            end
        end
    end

    // Access sequencer with registered completion, load data and peripheral strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            p_rd_q    <= 1'b0;
            p_wr_q    <= 1'b0;
            p_addr_q  <= '0;
            p_wdata_q <= '0;
            p_be_q    <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            sign_q    <= 1'b0;
            lo_q      <= '0;
            wr_op_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    if (req_d) begin
                        if (misalign_d) begin
                            rdata_q <= '0;
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= DONE;
                        end else if (is_ram_d) begin
                            rdata_q <= wr ? 32'h0 : extract(ram_word_d, size, sign, addr[1:0]);
                            ready_q <= 1'b1;
                            state_q <= RAM_DONE;
                        end else begin
                            p_rd_q    <= ~wr;
                            p_wr_q    <= wr;
                            p_addr_q  <= addr;
                            p_wdata_q <= lane_wdata_d;
                            p_be_q    <= be_d;
                            cnt_q     <= '0;
                            size_q    <= size;
                            sign_q    <= sign;
                            lo_q      <= addr[1:0];
                            wr_op_q   <= wr;
                            state_q   <= PERI_WAIT;
                        end
                    end
                end
                PERI_WAIT: begin
                    if (p_ack) begin
                        rdata_q <= wr_op_q ? 32'h0 : extract(p_rdata, size_q, sign_q, lo_q);
                        ready_q <= 1'b1;
                        err_q   <= 1'b0;
                        p_rd_q  <= 1'b0;
                        p_wr_q  <= 1'b0;
                        state_q <= DONE;
                    end else if (cnt_q == 8'(PERI_TIMEOUT - 1)) begin
                        rdata_q <= '0;
                        ready_q <= 1'b1;
                        err_q   <= 1'b1;
                        p_rd_q  <= 1'b0;
                        p_wr_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rdata   = rdata_q;
    assign ready   = ready_q;
    assign err     = err_q;
    assign p_rd    = p_rd_q;
    assign p_wr    = p_wr_q;
    assign p_addr  = p_addr_q;
    assign p_wdata = p_wdata_q;
    assign p_be    = p_be_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        rd, wr, sign, ready, err, p_rd, p_wr, p_ack;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata, p_addr, p_wdata, p_rdata;
    logic [3:0]  p_be;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] got_rdata, got_wd, got_pa;
    logic        got_err;
    logic [3:0]  got_be;
    int          lat, strobes, pulses;

    data_mem_ctrl dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .size(size), .sign(sign),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
        .p_rd(p_rd), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata), .p_be(p_be),
        .p_rdata(p_rdata), .p_ack(p_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Issue one access from a negedge and wait (bounded) for ready; acks the peripheral
    // on the ack_after-th strobe cycle (0 = never).
    task automatic access(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] d,
                          input int ack_after, input logic [31:0] prd);
        bit done = 0;
        lat = 0; strobes = 0; got_be = 'x; got_wd = 'x; got_pa = 'x;
        rd = ~w; wr = w; size = sz; sign = sg; addr = a; wdata = d;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            lat++;
            p_ack = 1'b0;
            if (ready) begin
                got_rdata = rdata; got_err = err; done = 1;
            end else if (p_rd | p_wr) begin
                strobes++;
                got_be = p_be; got_wd = p_wdata; got_pa = p_addr;
                if (ack_after != 0 && strobes == ack_after) begin
                    p_ack = 1'b1; p_rdata = prd;
                end
            end
        end
        rd = 0; wr = 0; p_ack = 0;
        if (!done) check("ready_bound", 32'(done), 32'd1);
        @(negedge clk);
        check("ready_one_cycle", 32'(ready), 32'd0);
        check("rdata_hold", rdata, got_rdata);
    endtask

    initial begin
        reset = 1; rd = 0; wr = 0; size = 0; sign = 0; addr = 0; wdata = 0;
        p_rdata = 0; p_ack = 0;
        #2;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_err",   32'(err),   32'd0);
        check("rst_rdata", rdata,      32'd0);
        check("rst_p_rd",  32'(p_rd),  32'd0);
        check("rst_p_wr",  32'(p_wr),  32'd0);
        check("rst_p_be",  32'(p_be),  32'd0);
        @(negedge clk); @(negedge clk);
        reset = 0;
        @(negedge clk);

        access(1, 2'b10, 0, 32'h10, 32'h11223344, 0, 0);
        check("sw_lat", lat, 1); check("sw_err", 32'(got_err), 0); check("sw_rdata", got_rdata, 0);
        access(1, 2'b00, 0, 32'h11, 32'h000000AA, 0, 0);
        check("sb_lat", lat, 1);
        access(0, 2'b10, 0, 32'h10, 0, 0, 0);
        check("lw_lat", lat, 1); check("lw_rdata", got_rdata, 32'h1122AA44); check("lw_err", 32'(got_err), 0);
        access(0, 2'b01, 0, 32'h12, 0, 0, 0);
        check("lhu_hi", got_rdata, 32'h00001122);

        access(1, 2'b10, 0, 32'h20, 32'h0000F080, 0, 0);
        access(0, 2'b00, 1, 32'h20, 0, 0, 0);
        check("lb_sext", got_rdata, 32'hFFFFFF80);
        access(0, 2'b01, 0, 32'h20, 0, 0, 0);
        check("lhu", got_rdata, 32'h0000F080);
        access(0, 2'b01, 1, 32'h20, 0, 0, 0);
        check("lh_sext", got_rdata, 32'hFFFFF080);
        access(0, 2'b00, 0, 32'h21, 0, 0, 0);
        check("lbu_lane1", got_rdata, 32'h000000F0);
        access(0, 2'b11, 0, 32'h20, 0, 0, 0);
        check("size11_word", got_rdata, 32'h0000F080);

        access(0, 2'b10, 0, 32'h12, 0, 0, 0);
`ifdef DMEM_ALIGN_CHECK_EN
        check("mis_err", 32'(got_err), 1); check("mis_rdata", got_rdata, 0);
        access(0, 2'b10, 0, 32'h10, 0, 0, 0);
        check("mis_ram_kept", got_rdata, 32'h1122AA44);
`else
        check("mis_err", 32'(got_err), 0); check("mis_word", got_rdata, 32'h1122AA44);
`endif

        access(0, 2'b10, 0, 32'h40000010, 0, 3, 32'hCAFEF00D);
        check("plw_strobes", strobes, 3); check("plw_rdata", got_rdata, 32'hCAFEF00D);
        check("plw_err", 32'(got_err), 0); check("plw_addr", got_pa, 32'h40000010);
        check("plw_be", 32'(got_be), 32'hF);

        access(1, 2'b00, 0, 32'h40000003, 32'h0000005A, 1, 0);
        check("psb_be", 32'(got_be), 32'h8); check("psb_wdata", got_wd, 32'h5A000000);
        check("psb_rdata", got_rdata, 0); check("psb_strobes", strobes, 1);

        access(0, 2'b00, 1, 32'h40000001, 0, 2, 32'h00008000);
        check("plb_sext", got_rdata, 32'hFFFFFF80); check("plb_be", 32'(got_be), 32'h2);

        access(1, 2'b10, 0, 32'h40000000, 32'hDEADBEEF, 0, 0);
        check("tmo_strobes", strobes, 15); check("tmo_err", 32'(got_err), 1);
        check("tmo_rdata", got_rdata, 0); check("tmo_wdata", got_wd, 32'hDEADBEEF);
        check("tmo_lat", lat, 16);

        rd = 1; wr = 0; size = 2'b10; sign = 0; addr = 32'h40000020;
        strobes = 0;
        for (int i = 0; i < 10 && strobes < 2; i++) begin
            @(negedge clk);
            if (p_rd) strobes++;
        end
        check("mid_reached", strobes, 2);
        reset = 1; rd = 0;
        #1;
        check("mid_p_rd_drop", 32'(p_rd), 0);
        check("mid_ready", 32'(ready), 0);
        @(negedge clk);
        reset = 0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        check("mid_no_pulse", pulses, 0);
        check("mid_rdata_rst", rdata, 0);
        access(0, 2'b10, 0, 32'h10, 0, 0, 0);
        check("post_rst_lw", got_rdata, 32'h1122AA44); check("post_rst_err", 32'(got_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
